// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered display word.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  output logic [3:0]              dec_code,
  input  logic [6:0]              dec_seg,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int WW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {HOLD, RUN_BLANK, RUN_SHOW} state_t;
  localparam state_t SLOT_FIRST = (BLANK_CYC > 0) ? RUN_BLANK : RUN_SHOW;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_inc;
  logic [IW-1:0]           idx;
  logic [WW-1:0]           shadow, pending;
  logic                    pending_full;
  logic                    run, slot_end, frame_end, boundary, xfer, accept;
  logic                    digit_vis;
  logic [NUM_DIGITS-1:0]   onehot, digit_en_d;
  logic [6:0]              seg_d;

  assign run       = (state != HOLD);
  assign cnt_inc   = cnt + 1'b1;
  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == IDX_MAX);
  assign boundary  = en && run && frame_end;
  // While scanning is held the pending word is taken over right away.
  assign xfer      = pending_full && (!en || boundary);
  assign accept    = wr_valid && wr_ready;
  assign onehot    = NUM_DIGITS'(1) << idx;
  assign dec_code  = shadow[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [WW-1:0] upper;
  assign upper     = shadow >> {idx, 2'b00};
  assign digit_vis = (idx == '0) || (upper != '0);
`else
  assign digit_vis = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      frame_start <= boundary || (en && !run);
      if (!en || !run) begin
        cnt <= '0;
        idx <= '0;
      end else if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

  // NOTE: the word registers are reset too, so a reset clears the display, not just control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      wr_ready     <= 1'b1;
    end else if (xfer) begin
      shadow       <= pending;
      pending_full <= 1'b0;
      wr_ready     <= 1'b1;
    end else if (accept) begin
      pending      <= wr_data;
      pending_full <= 1'b1;
      wr_ready     <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      HOLD:      if (en) state_d = SLOT_FIRST;
      RUN_BLANK: if (!en) state_d = HOLD;
                 else if (cnt_inc == BLANK) state_d = RUN_SHOW;
      RUN_SHOW:  if (!en) state_d = HOLD;
                 else if (slot_end) state_d = SLOT_FIRST;
      default:   state_d = HOLD;
    endcase
  end

  always_comb begin
    digit_en_d = '0;
    seg_d      = '0;
    if (en && (state == RUN_SHOW) && digit_vis) begin
      digit_en_d = onehot;
      seg_d      = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_en <= '0;
      seg_out  <= '0;
    end else begin
      digit_en <= digit_en_d;
      seg_out  <= seg_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
// Define LEADING_ZERO_BLANK_EN for both RTL and bench to exercise leading-zero blanking.
module tb_display_scan_ctrl;

  localparam int ND   = 4;
  localparam int DIVP = 8;
  localparam int BLK  = 2;
  localparam int FRM  = ND * DIVP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic [3:0]  dec_code;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_out;
  logic [3:0]  digit_en;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_lut(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  assign dec_seg = seg_lut(dec_code);

  display_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIVP), .BLANK_CYC(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .dec_code(dec_code), .dec_seg(dec_seg), .seg_out(seg_out),
    .digit_en(digit_en), .frame_start(frame_start)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] nib(input logic [15:0] w, input int k);
    logic [15:0] s;
    s = w >> (4 * k);
    return s[3:0];
  endfunction

  function automatic bit vis(input logic [15:0] w, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] s;
    s = w >> (4 * k);
    return (k == 0) || (s != 16'h0);
`else
    return (k >= 0);
`endif
  endfunction

  task automatic wait_fs(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s wait_frame_start: no pulse within 100 cycles, expected one", tag);
    end
  endtask

  // mode 0: wait for frame_start; 1: it must come at the next negedge; 2: current negedge is frame start.
  task automatic check_frame(input logic [15:0] word, input int mode, input bit dark0, input string tag);
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    bit         lit;
    int         pi;
    if (mode == 0) begin
      wait_fs(tag);
    end else if (mode == 1) begin
      @(negedge clk);
      n_checks++;
      if (frame_start !== 1'b1) begin
        n_fail++;
        $display("FAIL %s frame_align: frame_start=%b expected 1", tag, frame_start);
      end
    end
    for (int t = 0; t < FRM; t++) begin
      if (t > 0) @(negedge clk);
      n_checks++;
      if (frame_start !== (t == 0)) begin
        n_fail++;
        $display("FAIL %s t=%0d frame_start got %b expected %b", tag, t, frame_start, (t == 0));
      end
      n_checks++;
      if (dec_code !== nib(word, t / DIVP)) begin
        n_fail++;
        $display("FAIL %s t=%0d dec_code got %h expected %h", tag, t, dec_code, nib(word, t / DIVP));
      end
      if (t > 0 || dark0) begin
        lit = 1'b0;
        pi  = 0;
        if (t > 0) begin
          pi  = (t - 1) / DIVP;
          lit = (((t - 1) % DIVP) >= BLK) && vis(word, pi);
        end
        exp_en  = lit ? 4'(1 << pi) : 4'h0;
        exp_seg = lit ? seg_lut(nib(word, pi)) : 7'h00;
        n_checks++;
        if (digit_en !== exp_en) begin
          n_fail++;
          $display("FAIL %s t=%0d digit_en got %b expected %b", tag, t, digit_en, exp_en);
        end
        n_checks++;
        if (seg_out !== exp_seg) begin
          n_fail++;
          $display("FAIL %s t=%0d seg_out got %h expected %h", tag, t, seg_out, exp_seg);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    en    = 1'b0;
    #3 rst_n = 1'b0;
    #4;
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset wr_ready got %b expected 1", wr_ready); end
    n_checks++;
    if (digit_en !== 4'h0) begin n_fail++; $display("FAIL reset digit_en got %b expected 0000", digit_en); end
    n_checks++;
    if (seg_out !== 7'h00) begin n_fail++; $display("FAIL reset seg_out got %h expected 00", seg_out); end
    n_checks++;
    if (dec_code !== 4'h0) begin n_fail++; $display("FAIL reset dec_code got %h expected 0", dec_code); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset frame_start got %b expected 0", frame_start); end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_idle_scan;
    check_frame(16'h0000, 1, 1'b1, "idle0");
    check_frame(16'h0000, 1, 1'b0, "idle1");
  endtask

  task automatic test_write;
    wait_fs("wr");
    repeat (5) @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr ready_before got %b expected 1", wr_ready); end
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = '0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr accept got wr_ready=%b expected 0", wr_ready); end
    for (int t = 7; t < FRM; t++) begin
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr hold t=%0d wr_ready got %b expected 0", t, wr_ready); end
    end
    check_frame(16'h1234, 1, 1'b0, "wr1234");
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr ready_after got %b expected 1", wr_ready); end
  endtask

  task automatic test_back_to_back;
    int waited;
    wait_fs("b2b");
    repeat (3) @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 16'hAAAA;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b first_accept wr_ready got %b expected 0", wr_ready); end
    wr_data = 16'h5555;
    waited  = 0;
    while (wr_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited != 28) begin n_fail++; $display("FAIL b2b stall_len got %0d cycles expected 28", waited); end
    n_checks++;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL b2b ready_at_frame frame_start got %b expected 1", frame_start); end
    fork
      check_frame(16'hAAAA, 2, 1'b0, "b2bA");
      begin
        @(negedge clk);
        wr_valid = 1'b0;
        wr_data  = '0;
        n_checks++;
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b second_accept wr_ready got %b expected 0", wr_ready); end
      end
    join
    check_frame(16'h5555, 1, 1'b0, "b2b5");
  endtask

  task automatic test_boundary_write;
    wait_fs("bnd");
    repeat (FRM - 1) @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL bnd ready got %b expected 1", wr_ready); end
    wr_valid = 1'b1;
    wr_data  = 16'h9876;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = '0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bnd accept wr_ready got %b expected 0", wr_ready); end
    n_checks++;
    if (dec_code !== 4'h5) begin n_fail++; $display("FAIL bnd old_word dec_code got %h expected 5", dec_code); end
    check_frame(16'h5555, 2, 1'b0, "bnd_old");
    check_frame(16'h9876, 1, 1'b0, "bnd_new");
  endtask

  task automatic test_en_drop;
    wait_fs("en");
    repeat (20) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (digit_en !== 4'h0) begin n_fail++; $display("FAIL en dark digit_en got %b expected 0000", digit_en); end
    n_checks++;
    if (seg_out !== 7'h00) begin n_fail++; $display("FAIL en dark seg_out got %h expected 00", seg_out); end
    n_checks++;
    if (dec_code !== 4'h6) begin n_fail++; $display("FAIL en idx0 dec_code got %h expected 6", dec_code); end
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL en ready got %b expected 1", wr_ready); end
    wr_valid = 1'b1;
    wr_data  = 16'h4321;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = '0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL en accept wr_ready got %b expected 0", wr_ready); end
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL en drain wr_ready got %b expected 1", wr_ready); end
    n_checks++;
    if (dec_code !== 4'h1) begin n_fail++; $display("FAIL en shadow dec_code got %h expected 1", dec_code); end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (digit_en !== 4'h0 || frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL en held digit_en=%b frame_start=%b expected 0000 and 0", digit_en, frame_start);
      end
    end
    en = 1'b1;
    check_frame(16'h4321, 1, 1'b1, "restart");
  endtask

  task automatic test_reset_mid;
    wait_fs("rst");
    repeat (4) @(negedge clk);
    n_checks++;
    if (digit_en !== 4'b0001) begin n_fail++; $display("FAIL rst lit_before digit_en got %b expected 0001", digit_en); end
    wr_valid = 1'b1;
    wr_data  = 16'hBEEF;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = '0;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst pending wr_ready got %b expected 0", wr_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (digit_en !== 4'h0) begin n_fail++; $display("FAIL rst async digit_en got %b expected 0000", digit_en); end
    n_checks++;
    if (seg_out !== 7'h00) begin n_fail++; $display("FAIL rst async seg_out got %h expected 00", seg_out); end
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst async wr_ready got %b expected 1", wr_ready); end
    n_checks++;
    if (dec_code !== 4'h0) begin n_fail++; $display("FAIL rst async dec_code got %h expected 0", dec_code); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, 1, 1'b1, "post_rst0");
    check_frame(16'h0000, 1, 1'b0, "post_rst1");
  endtask

  task automatic test_leading_zero;
    wait_fs("lz");
    wr_valid = 1'b1;
    wr_data  = 16'h0070;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = '0;
    check_frame(16'h0070, 0, 1'b0, "lz0070");
    wait_fs("lz");
    wr_valid = 1'b1;
    wr_data  = 16'h0000;
    @(negedge clk);
    wr_valid = 1'b0;
    check_frame(16'h0000, 0, 1'b0, "lz0000");
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_write();
    test_back_to_back();
    test_boundary_write();
    test_en_drop();
    test_reset_mid();
    test_leading_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-segment 7-segment display.
- Holds a multi-digit nibble word behind a valid/ready write port and steps through the digits one per time slot.
- Presents each digit's nibble to the shared combinational nibble-to-segment decoder and gates the decoder's 7-bit pattern out with a one-hot digit enable.
- Inserts a dead-time blank at the start of every slot to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant.
- DIV, 1000, clock cycles per digit slot (>= 4).
- BLANK_CYC, 16, dead-time cycles at the start of each slot; must be < DIV, may be 0.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 = display dark and scan held at digit 0.
- wr_valid  in  1  write request.
- wr_data  in  4*NUM_DIGITS  new display word; nibble k = digit k.
- wr_ready  out  1  write port can accept.
- dec_code  out  4  nibble to shared segment decoder.
- dec_seg  in  7  decoder output pattern (bit0=a .. bit6=g, active high).
- seg_out  out  7  segment drive, active high.
- digit_en  out  NUM_DIGITS  one-hot digit select, active high.
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (async, rst_n=0) sets every state element to its reset value:
  - slot counter cnt=0, digit index idx=0, shadow word=0, pending buffer empty.
  - wr_ready=1, digit_en=0, seg_out=0, dec_code=0, frame_start=0.
  - Reset mid-slot or mid-write discards the pending word and the shadow word.
- Write port:
  - A transfer occurs on a rising edge with wr_valid & wr_ready; the word goes to the pending buffer.
  - wr_ready is registered and equals NOT pending_full.
  - wr_data need only be stable while wr_valid=1.
- Slot timing (en=1): cnt counts 0..DIV-1.
  - cnt < BLANK_CYC: digit_en=0 and seg_out=0.
  - Otherwise: digit_en=one-hot(idx) and seg_out=dec_seg.
  - digit_en and seg_out are registered, so they reflect the state from one cycle earlier.
  - dec_code = shadow nibble[idx], combinational from registers and stable for the whole slot. The decoder path is combinational.
- Slot end (cnt=DIV-1): cnt->0 and idx->idx+1.
  - When idx=NUM_DIGITS-1, idx wraps to 0; this is the frame boundary.
  - frame_start is asserted for one cycle in the first cycle of the new frame (cnt=0, idx=0).
- Frame boundary: if pending is full, shadow <= pending, pending is emptied, and wr_ready goes to 1 the following cycle.
  - The shadow word changes only at frame boundaries, so a frame never mixes old and new words.
- Simultaneous events:
  - A write accepted in the boundary cycle while pending is empty is not applied at that boundary; it is applied at the next one.
  - A write attempted while pending is full stalls (wr_ready=0) until the boundary drains pending.
- en=0 (synchronous):
  - Next cycle: cnt=0, idx=0, digit_en=0, seg_out=0, no frame_start.
  - The write port stays operational.
  - A pending word transfers to shadow immediately (on the next edge) while en=0.
  - On en 0->1, scanning restarts at digit 0, cnt=0, and frame_start pulses on the first enabled cycle.
- State machine: RUN_BLANK (cnt<BLANK_CYC) -> RUN_SHOW -> RUN_BLANK at slot end. Any state -> HOLD on en=0; HOLD -> RUN_BLANK on en=1.
- Width rules:
  - cnt width is clog2(DIV).
  - idx width is clog2(NUM_DIGITS), minimum 1.
  - No arithmetic on data nibbles; values 10..15 pass to the decoder unchanged.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN
- Defined: during a slot for digit k>0, digit_en and seg_out are held 0 for the entire slot if nibbles k..NUM_DIGITS-1 of the shadow word are all 4'h0. Slot timing is unchanged. Digit 0 is always displayed.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan:
(Bench uses NUM_DIGITS=4, DIV=8, BLANK_CYC=2, with the real nibble decoder attached.)
- Reset then en=1, no writes -> dec_code=0 on every slot; digit_en sequence 0001,0010,0100,1000 each high 6 of 8 cycles; seg_out=7'h3F when lit; frame_start pulses every 32 cycles.
- Write 16'h1234 mid-frame -> accepted in 1 cycle, wr_ready low until the next frame_start. From that frame: digit0 seg=7'h66 (4), digit1 7'h4F (3), digit2 7'h5B (2), digit3 7'h06 (1).
- Back-to-back writes 16'hAAAA then 16'h5555 in the same frame -> second stalls with wr_ready=0 until the boundary. Next frame shows A (7'h77); the frame after shows 5 (7'h6D).
- Write accepted exactly in the cycle with cnt=7 and idx=3 -> the new word appears at the second frame boundary, not the first.
- Drop en for 5 cycles mid-slot of digit 2 -> digit_en=0 and seg_out=0 from the next cycle. After re-enable, digit 0 lights after 2 blank cycles and frame_start pulses.
- Assert rst_n low mid-slot with a pending write -> all outputs 0 immediately without a clock edge; after release the shadow word is 0 and wr_ready=1.
- With LEADING_ZERO_BLANK_EN defined, word 16'h0070 -> digits 3 and 2 dark for the whole slot, digit 1 shows 7'h07, digit 0 shows 7'h3F. Word 16'h0000 -> only digit 0 lit.
